aes_run_sequencer: RTL

Sequencer that drives the AES core's encryption port on behalf of the AXI4-Lite register front end. A single command runs N encryptions back to back. For each one the block loads key and plaintext, issues the start pulse, waits for completion with a timeout, and captures the ciphertext. It also emits a programmable oscilloscope trigger pulse per encryption, so side-channel traces are aligned to the core's computation.

---
 rtl/aes_run_sequencer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_run_sequencer.sv
// aes_run_sequencer: drives the AES core encryption port for a run of N
// back-to-back encryptions. Each encryption goes through load, start, wait
// and capture. A scope trigger pulse with programmable delay and width is
// emitted once per encryption. The next encryption does not start until
// that pulse has ended.
module aes_run_sequencer #(
  parameter int DATA_W  = 128,
  parameter int CNT_W   = 16,
  parameter int DLY_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [DATA_W-1:0] cfg_key,
  input  logic [DATA_W-1:0] cfg_pt,
  input  logic [CNT_W-1:0]  cfg_repeat,
  input  logic              cfg_chain,
  input  logic [DLY_W-1:0]  cfg_trig_dly,
  input  logic [DLY_W-1:0]  cfg_trig_len,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_din,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout,
  output logic              trig,
  output logic [DATA_W-1:0] ct,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  run_cnt
);

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE} state_e;
  typedef enum logic [1:0] {T_OFF, T_DLY, T_HIGH} tstate_e;

  state_e              state_q, state_d;
  tstate_e             tst_q, tst_d;
  logic [DLY_W-1:0]    tcnt_q, tcnt_d;
  logic                trig_q, trig_d;
  logic [TO_W-1:0]     tocnt_q, tocnt_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   pt_q, pt_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   ct_q, ct_d;
  logic [CNT_W-1:0]    rep_q, rep_d;
  logic                chain_q, chain_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [DLY_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // A repeat count of zero still means one encryption.
  function automatic logic [CNT_W-1:0] eff_repeat(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // A trigger length of zero still produces a one-cycle pulse.
  function automatic logic [DLY_W-1:0] eff_len(input logic [DLY_W-1:0] v);
    return (v == '0) ? DLY_W'(1) : v;
  endfunction

  // The completed-encryption counter never goes past the run length.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

  // Next-state logic for the run FSM, the trigger generator and the datapath.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    pt_d    = pt_q;
    din_d   = din_q;
    ct_d    = ct_q;
    rep_d   = rep_q;
    chain_d = chain_q;
    dly_d   = dly_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    tocnt_d = tocnt_q;
    tst_d   = tst_q;
    tcnt_d  = tcnt_q;
    trig_d  = trig_q;

    // The trigger runs on its own once START arms it: delay, then the high phase.
    case (tst_q)
      T_DLY: begin
        if (tcnt_q == '0) begin
          trig_d = 1'b1;
          tst_d  = T_HIGH;
          tcnt_d = len_q - DLY_W'(1);
        end else begin
          tcnt_d = tcnt_q - DLY_W'(1);
        end
      end
      T_HIGH: begin
        if (tcnt_q == '0) begin
          trig_d = 1'b0;
          tst_d  = T_OFF;
        end else begin
          tcnt_d = tcnt_q - DLY_W'(1);
        end
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (cmd_start && !cmd_abort) begin
          key_d   = cfg_key;
          pt_d    = cfg_pt;
          din_d   = cfg_pt;
          rep_d   = eff_repeat(cfg_repeat);
          chain_d = cfg_chain;
          dly_d   = cfg_trig_dly;
          len_d   = eff_len(cfg_trig_len);
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        tocnt_d = '0;
        // A zero delay means the trigger rises in the cycle right after core_start.
        if (dly_q == '0) begin
          trig_d = 1'b1;
          tst_d  = T_HIGH;
          tcnt_d = len_q - DLY_W'(1);
        end else begin
          tst_d  = T_DLY;
          tcnt_d = dly_q - DLY_W'(1);
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          ct_d    = core_dout;
          cnt_d   = sat_inc(cnt_q, rep_q);
          state_d = S_CAPTURE;
        end else if (tocnt_q == TO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          tst_d   = T_OFF;
          tcnt_d  = '0;
          trig_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tocnt_d = tocnt_q + TO_W'(1);
        end
      end
      S_CAPTURE: begin
        // Stay here until the trigger pulse is over, so pulses never merge.
        if (tst_q == T_OFF) begin
          if (cnt_q == rep_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            din_d   = chain_q ? ct_q : pt_q;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort ends the run quietly: no done flag, counter and ciphertext kept.
    if (cmd_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      din_d   = din_q;
      ct_d    = ct_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      err_d   = err_q;
      tst_d   = T_OFF;
      tcnt_d  = '0;
      trig_d  = 1'b0;
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      tst_q   <= T_OFF;
      tcnt_q  <= '0;
      trig_q  <= 1'b0;
      tocnt_q <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      din_q   <= '0;
      ct_q    <= '0;
      rep_q   <= '0;
      chain_q <= 1'b0;
      dly_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tst_q   <= tst_d;
      tcnt_q  <= tcnt_d;
      trig_q  <= trig_d;
      tocnt_q <= tocnt_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      din_q   <= din_d;
      ct_q    <= ct_d;
      rep_q   <= rep_d;
      chain_q <= chain_d;
      dly_q   <= dly_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign core_key    = key_q;
  assign core_din    = din_q;
  assign core_start  = (state_q == S_START) && !cmd_abort;
  assign trig        = trig_q;
  assign ct          = ct_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign run_cnt     = cnt_q;

endmodule
